// File: rtl/sonic_st_ready_latency_adapter.sv
// Avalon-ST timing adapter: upstream ready latency IN_RL (0..3) to downstream ready latency 0,
// buffered by a DEPTH-entry show-ahead FIFO. Define SONIC_ST_TA_ERR_CHECK_EN for err_overrun.
module sonic_st_ready_latency_adapter #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IN_RL  = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill_level
`ifdef SONIC_ST_TA_ERR_CHECK_EN
    ,
    output logic                   err_overrun
`endif
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HIST_W = (IN_RL > 0) ? IN_RL : 1;
    localparam int unsigned SUM_W  = CNT_W + 3;

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [HIST_W-1:0] rdy_hist_q, rdy_hist_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic             push;
    logic             pop;
    logic [2:0]       hist_ones;
    logic [SUM_W-1:0] credit_sum;

    // Every credit granted in the last IN_RL cycles may still land, so it reserves a slot.
    always_comb begin
        hist_ones = 3'd0;
        for (int i = 0; i < int'(HIST_W); i++) begin
            hist_ones = hist_ones + 3'(rdy_hist_q[i]);
        end
        credit_sum = SUM_W'(count_q) + SUM_W'(hist_ones) + SUM_W'(1);
        in_ready   = reset_n && (credit_sum <= SUM_W'(DEPTH));
    end

    always_comb begin
        out_valid  = (count_q != '0);
        out_data   = mem_q[rd_ptr_q];
        fill_level = count_q;
        pop        = out_valid && out_ready;
        push       = in_valid && ((count_q != DepthCnt) || pop);
    end

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rdy_hist_d = '0;

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        for (int i = int'(HIST_W) - 1; i > 0; i--) begin
            rdy_hist_d[i] = rdy_hist_q[i-1];
        end
        rdy_hist_d[0] = (IN_RL > 0) ? in_ready : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rdy_hist_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rdy_hist_q <= rdy_hist_d;
        end
    end

    // Payload storage needs no reset; out_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef SONIC_ST_TA_ERR_CHECK_EN
    logic err_overrun_q, err_overrun_d;
    logic credit;
    logic err_event;

    // Credit for this cycle's beat is in_ready as seen IN_RL cycles ago.
    always_comb begin
        credit        = (IN_RL == 0) ? in_ready : rdy_hist_q[HIST_W-1];
        err_event     = in_valid && (!push || !credit);
        err_overrun_d = err_overrun_q || err_event;
        err_overrun   = err_overrun_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overrun_q <= 1'b0;
        end else begin
            err_overrun_q <= err_overrun_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && err_event) begin
            $display("%m: upstream protocol violation (beat without credit or dropped)");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sonic_st_ready_latency_adapter.sv
// Self-checking bench: an IN_RL=0 and an IN_RL=2 adapter (DEPTH=4, DATA_W=2) driven by directed
// and random stimulus, checked against a queue-based reference model.
module tb_sonic_st_ready_latency_adapter;

    localparam int unsigned DW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid0, in_ready0, out_valid0, out_ready0;
    logic [DW-1:0] in_data0, out_data0;
    logic [2:0]    fill0;
    logic          in_valid2, in_ready2, out_valid2, out_ready2;
    logic [DW-1:0] in_data2, out_data2;
    logic [2:0]    fill2;
`ifdef SONIC_ST_TA_ERR_CHECK_EN
    logic          err0, err2;
`endif

    sonic_st_ready_latency_adapter #(.DATA_W(DW), .DEPTH(DEPTH), .IN_RL(0)) u_dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid0),
        .in_data    (in_data0),
        .in_ready   (in_ready0),
        .out_valid  (out_valid0),
        .out_data   (out_data0),
        .out_ready  (out_ready0),
        .fill_level (fill0)
`ifdef SONIC_ST_TA_ERR_CHECK_EN
        ,
        .err_overrun(err0)
`endif
    );

    sonic_st_ready_latency_adapter #(.DATA_W(DW), .DEPTH(DEPTH), .IN_RL(2)) u_dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid2),
        .in_data    (in_data2),
        .in_ready   (in_ready2),
        .out_valid  (out_valid2),
        .out_data   (out_data2),
        .out_ready  (out_ready2),
        .fill_level (fill2)
`ifdef SONIC_ST_TA_ERR_CHECK_EN
        ,
        .err_overrun(err2)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: FIFO contents as queues; h2[0]/h2[1] = in_ready one/two cycles ago.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q2[$];
    logic          h2[$];
    logic          merr0, merr2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_rdy0();
        return (q0.size() + 1 <= DEPTH);
    endfunction

    function automatic logic exp_rdy2();
        return (q2.size() + int'(h2[0]) + int'(h2[1]) + 1 <= DEPTH);
    endfunction

    task automatic clear_model();
        q0.delete();
        q2.delete();
        h2.delete();
        h2.push_back(1'b0);
        h2.push_back(1'b0);
        merr0 = 1'b0;
        merr2 = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("rl0_in_ready", in_ready0, exp_rdy0());
        check_eq("rl0_out_valid", out_valid0, q0.size() != 0);
        check_eq("rl0_fill", fill0, q0.size());
        if (q0.size() != 0) check_eq("rl0_out_data", out_data0, q0[0]);
        check_eq("rl2_in_ready", in_ready2, exp_rdy2());
        check_eq("rl2_out_valid", out_valid2, q2.size() != 0);
        check_eq("rl2_fill", fill2, q2.size());
        if (q2.size() != 0) check_eq("rl2_out_data", out_data2, q2[0]);
`ifdef SONIC_ST_TA_ERR_CHECK_EN
        check_eq("rl0_err", err0, merr0);
        check_eq("rl2_err", err2, merr2);
`endif
    endtask

    // One clock cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic cycle(input logic v0, input logic [DW-1:0] d0, input logic r0,
                         input logic v2, input logic [DW-1:0] d2, input logic r2);
        logic rdy0, rdy2, pop0, pop2, push0, push2;
        in_valid0  = v0;
        in_data0   = d0;
        out_ready0 = r0;
        in_valid2  = v2;
        in_data2   = d2;
        out_ready2 = r2;
        @(negedge clk);
        check_outputs();
        rdy0  = exp_rdy0();
        rdy2  = exp_rdy2();
        pop0  = (q0.size() != 0) && r0;
        push0 = v0 && ((q0.size() < DEPTH) || pop0);
        pop2  = (q2.size() != 0) && r2;
        push2 = v2 && ((q2.size() < DEPTH) || pop2);
        merr0 = merr0 | (v0 && (!push0 || !rdy0));
        merr2 = merr2 | (v2 && (!push2 || !h2[1]));
        if (pop0) void'(q0.pop_front());
        if (push0) q0.push_back(d0);
        if (pop2) void'(q2.pop_front());
        if (push2) q2.push_back(d2);
        h2.push_front(rdy2);
        void'(h2.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        in_valid0  = 1'b0;
        in_valid2  = 1'b0;
        out_ready0 = 1'b0;
        out_ready2 = 1'b0;
        #1;
        check_eq("rst_rl0_out_valid", out_valid0, 1'b0);
        check_eq("rst_rl0_fill", fill0, 3'd0);
        check_eq("rst_rl0_in_ready", in_ready0, 1'b0);
        check_eq("rst_rl2_out_valid", out_valid2, 1'b0);
        check_eq("rst_rl2_fill", fill2, 3'd0);
        check_eq("rst_rl2_in_ready", in_ready2, 1'b0);
`ifdef SONIC_ST_TA_ERR_CHECK_EN
        check_eq("rst_rl0_err", err0, 1'b0);
        check_eq("rst_rl2_err", err2, 1'b0);
`endif
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic v0, r0, v2, r2;
        in_valid0  = 1'b0;
        in_data0   = '0;
        out_ready0 = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        do_reset();

        // Streaming on RL0; RL2 accepts credited beats with no downstream accept.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(i), 1'b1, h2[1], DW'(i), 1'b0);
        cycle(1'b0, '0, 1'b1, h2[1], 2'd3, 1'b0);
        // Fill RL0, pop one, refill, then push and pop together while full.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(3 - i), 1'b0, h2[1], DW'(i), 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 2'd2, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        // Beats without credit into full FIFOs are dropped.
        cycle(1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0);
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            r0 = ($urandom_range(0, 3) < ((i % 600) < 300 ? 3 : 1));
            r2 = ($urandom_range(0, 3) < ((i % 400) < 200 ? 1 : 3));
            v0 = exp_rdy0() ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            v2 = h2[1] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            cycle(v0, DW'($urandom), r0, v2, DW'($urandom), r2);
        end

        // Reset while three beats are buffered; nothing may emerge afterwards.
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(i + 1), 1'b0, 1'b1, DW'(i + 1), 1'b0);
        check_eq("pre_rst_rl0_fill", fill0, 3'd3);
        do_reset();
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
